pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Tracks destination registers in flight in EX/MEM/WB and issues operand-forwarding selects to the ID/EX operand muxes.
- Detects load-use hazards and inserts a bubble; flushes IF on a branch or jump taken in ID.
- Freezes the whole pipeline while the data memory is busy, with a timeout watchdog on that wait.

Parameters:
- REG_ADDR_W, 5, register address width.
- MEM_TIMEOUT, 255, maximum consecutive wait cycles before mem_timeout is raised. Legal range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  clock enable; no state update when low
- id_valid  in  1  ID holds a real instruction (not a bubble)
- rs1_addr_id  in  5  rs1 address of the ID instruction
- rs2_addr_id  in  5  rs2 address of the ID instruction
- rs1_used  in  1  ID instruction reads rs1
- rs2_used  in  1  ID instruction reads rs2
- rd_addr_id  in  5  rd address of the ID instruction
- rd_wr_en_id  in  1  ID instruction writes rd
- data_rd_en_id  in  1  ID instruction is a load
- branch_taken  in  1  branch or jump resolved taken in ID
- data_req  in  1  MEM stage is accessing data memory
- data_ready  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC and the IF/ID register
- stall_id  out  1  hold the ID/EX inputs
- bubble_ex  out  1  load a NOP into ID/EX
- flush_if  out  1  replace IF/ID with a NOP
- freeze  out  1  hold all pipeline registers
- fwd_rs1_sel  out  2  0=reg file, 1=EX/MEM, 2=MEM/WB, 3=WB writeback
- fwd_rs2_sel  out  2  same encoding as fwd_rs1_sel
- mem_timeout  out  1  sticky wait-timeout error flag

Behaviour:
- Tracking registers (all reset to 0, updated only when clk_en=1):
  - EX stage: ex_rd, ex_wr, ex_load.
  - MEM stage: mem_rd, mem_wr.
  - WB stage: wb_rd, wb_wr.
- Advance: when clk_en=1 and freeze=0, the tracking registers shift ID->EX->MEM->WB.
  - EX loads ID values qualified by id_valid.
  - When bubble_ex=1, EX loads zeros.
- Forwarding (combinational): for each used source rsN != 0, the first match in priority order wins:
  - ex_wr && ex_rd==rsN -> 1
  - mem_wr && mem_rd==rsN -> 2
  - wb_wr && wb_rd==rsN -> 3
  - otherwise 0.
  - x0 always selects 0. An unused source selects 0.
- Load-use hazard (lu, combinational): id_valid && ex_load && ex_rd!=0 && ((rs1_used && rs1_addr_id==ex_rd) || (rs2_used && rs2_addr_id==ex_rd)).
- Memory wait (mw, combinational): data_req && !data_ready.
- Priority, highest first: mw > lu > branch_taken.
  - mw: freeze=1, stall_if=1, stall_id=1; bubble_ex=0, flush_if=0.
  - lu (and no mw): stall_if=1, stall_id=1, bubble_ex=1. branch_taken is ignored; the branch resolves after the stall.
  - branch_taken (no mw, no lu): flush_if=1 for exactly that cycle.
- FSM, reset state RUN:
  - RUN -> WAIT on mw.
  - RUN -> LU on lu.
  - LU -> RUN after one advance. The load has moved to MEM, so the hazard clears via forwarding sel=2.
  - WAIT -> RUN on the cycle data_ready=1.
- Wait counter:
  - Counts cycles in WAIT; clears on leaving WAIT.
  - When the count reaches MEM_TIMEOUT, mem_timeout is set.
  - mem_timeout stays set until reset. The FSM stays in WAIT.
- clk_en=0: FSM, counter and tracking registers hold. Combinational outputs still reflect the current state and inputs.
- Reset (async assert, mid-operation included): FSM=RUN, counter=0, tracking=0, mem_timeout=0. All outputs are 0 while rst_n=0.
- Latency: hazard outputs are combinational, same cycle as their inputs. mem_timeout is registered (1 cycle).

Test Plan:
- Back-to-back ALU ops `add x5,..` then `sub x6,x5,x5` -> fwd_rs1_sel=fwd_rs2_sel=1, no stall. Next cycle with no match -> 0.
- `lw x7` then `add x8,x7,x1` -> one cycle stall_if=stall_id=bubble_ex=1. Following cycle fwd_rs1_sel=2, stalls 0.
- Load to x0 followed by a use of x0 -> no stall, fwd_sel=0.
- data_req=1, data_ready=0 for 3 cycles -> freeze=1 for 3 cycles, tracking holds. data_ready=1 -> freeze=0, advance.
- MEM_TIMEOUT=4, data_ready held 0 -> mem_timeout rises after the 4th wait cycle and stays high. Only rst_n=0 clears it.
- branch_taken concurrent with lu -> flush_if=0, stall=1. Next cycle branch_taken -> flush_if=1 for one cycle.
- rst_n pulsed low during WAIT -> all outputs 0 immediately, FSM RUN, tracking cleared.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: operand forwarding, load-use bubbles,
// branch flush and a pipeline freeze on data-memory waits with a timeout watchdog.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1_addr_id,
    input  logic [REG_ADDR_W-1:0] rs2_addr_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_addr_id,
    input  logic                  rd_wr_en_id,
    input  logic                  data_rd_en_id,
    input  logic                  branch_taken,
    input  logic                  data_req,
    input  logic                  data_ready,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if,
    output logic                  freeze,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
    output logic                  mem_timeout
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {ST_RUN, ST_LU, ST_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                    mem_timeout_q, mem_timeout_d;
    logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic                    ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
    logic                    ex_load_q, ex_load_d;
    logic                    mw, lu, advance;

    // Youngest in-flight writer wins; x0 and unused sources always read the register file.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic used);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && rs != '0) begin
            if (ex_wr_q && ex_rd_q == rs)       sel = 2'd1;
            else if (mem_wr_q && mem_rd_q == rs) sel = 2'd2;
            else if (wb_wr_q && wb_rd_q == rs)   sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        mw = data_req && !data_ready;
        lu = id_valid && ex_load_q && (ex_rd_q != '0) &&
             ((rs1_used && rs1_addr_id == ex_rd_q) || (rs2_used && rs2_addr_id == ex_rd_q));
        advance = clk_en && !mw;

        // Outputs are forced low during reset even though mw/branch come straight from inputs.
        freeze      = rst_n && mw;
        stall_if    = rst_n && (mw || lu);
        stall_id    = rst_n && (mw || lu);
        bubble_ex   = rst_n && !mw && lu;
        flush_if    = rst_n && !mw && !lu && branch_taken;
        fwd_rs1_sel = rst_n ? fwd_sel(rs1_addr_id, rs1_used) : 2'd0;
        fwd_rs2_sel = rst_n ? fwd_sel(rs2_addr_id, rs2_used) : 2'd0;
        mem_timeout = mem_timeout_q;
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
        ex_rd_d   = ex_rd_q;
        ex_wr_d   = ex_wr_q;
        ex_load_d = ex_load_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        wb_rd_d   = wb_rd_q;
        wb_wr_d   = wb_wr_q;
        state_d   = state_q;

        if (advance) begin
            ex_rd_d   = (id_valid && !lu) ? rd_addr_id : '0;
            ex_wr_d   = id_valid && !lu && rd_wr_en_id;
            ex_load_d = id_valid && !lu && data_rd_en_id;
            mem_rd_d  = ex_rd_q;
            mem_wr_d  = ex_wr_q;
            wb_rd_d   = mem_rd_q;
            wb_wr_d   = mem_wr_q;
        end

        unique case (state_q)
            ST_RUN:  state_d = mw ? ST_WAIT : (lu ? ST_LU : ST_RUN);
            ST_LU:   state_d = mw ? ST_WAIT : ST_RUN;
            ST_WAIT: state_d = data_ready ? ST_RUN : ST_WAIT;
            default: state_d = ST_RUN;
        endcase

        if (state_d == ST_WAIT)
            wait_cnt_d = (wait_cnt_q == TIMEOUT_CNT) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        else
            wait_cnt_d = '0;
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == TIMEOUT_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            ex_rd_q       <= '0;
            ex_wr_q       <= 1'b0;
            ex_load_q     <= 1'b0;
            mem_rd_q      <= '0;
            mem_wr_q      <= 1'b0;
            wb_rd_q       <= '0;
            wb_wr_q       <= 1'b0;
        end else if (clk_en) begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            ex_rd_q       <= ex_rd_d;
            ex_wr_q       <= ex_wr_d;
            ex_load_q     <= ex_load_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            wb_rd_q       <= wb_rd_d;
            wb_wr_q       <= wb_wr_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the in-flight writer list and memory-wait watchdog.
module tb_pipeline_hazard_ctrl;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n, clk_en, id_valid, rs1_used, rs2_used, rd_wr_en_id, data_rd_en_id;
    logic       branch_taken, data_req, data_ready;
    logic [4:0] rs1_addr_id, rs2_addr_id, rd_addr_id;
    logic       stall_if, stall_id, bubble_ex, flush_if, freeze, mem_timeout;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: index 0 = EX, 1 = MEM, 2 = WB.
    logic [4:0] m_rd [3];
    logic       m_wr [3];
    logic       m_load, m_in_wait, m_to;
    int         m_cnt;
    logic       e_mw, e_lu;
    logic [9:0] e_vec;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .id_valid(id_valid),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_addr_id(rd_addr_id),
        .rd_wr_en_id(rd_wr_en_id), .data_rd_en_id(data_rd_en_id),
        .branch_taken(branch_taken), .data_req(data_req), .data_ready(data_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if(flush_if), .freeze(freeze), .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel), .mem_timeout(mem_timeout)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 2'd0;
        for (int i = 0; i < 3; i++)
            if (m_wr[i] && m_rd[i] == rs) return 2'(i + 1);
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 5'd0;
            m_wr[i] = 1'b0;
        end
        m_load = 0; m_in_wait = 0; m_to = 0; m_cnt = 0;
    endtask

    // Expected {stall_if, stall_id, bubble_ex, flush_if, freeze, fwd1, fwd2, mem_timeout}.
    task automatic model_eval();
        e_mw = data_req && !data_ready;
        e_lu = id_valid && m_load && m_rd[0] != 5'd0 &&
               ((rs1_used && rs1_addr_id == m_rd[0]) || (rs2_used && rs2_addr_id == m_rd[0]));
        if (!rst_n) e_vec = 10'd0;
        else e_vec = {e_mw || e_lu, e_mw || e_lu, !e_mw && e_lu, !e_mw && !e_lu && branch_taken,
                      e_mw, ref_fwd(rs1_addr_id, rs1_used), ref_fwd(rs2_addr_id, rs2_used), m_to};
    endtask

    task automatic model_clock();
        model_eval();
        if (!rst_n) begin
            model_reset();
        end else if (clk_en) begin
            if (!e_mw) begin
                m_rd[2] = m_rd[1]; m_wr[2] = m_wr[1];
                m_rd[1] = m_rd[0]; m_wr[1] = m_wr[0];
                m_rd[0] = (id_valid && !e_lu) ? rd_addr_id : 5'd0;
                m_wr[0] = id_valid && !e_lu && rd_wr_en_id;
                m_load  = id_valid && !e_lu && data_rd_en_id;
            end
            m_in_wait = m_in_wait ? !data_ready : e_mw;
            m_cnt = m_in_wait ? ((m_cnt < T) ? m_cnt + 1 : m_cnt) : 0;
            if (m_cnt >= T) m_to = 1'b1;
        end
    endtask

    always @(posedge clk) model_clock();
    always @(negedge rst_n) model_reset();

    function automatic logic [9:0] dut_vec();
        return {stall_if, stall_id, bubble_ex, flush_if, freeze, fwd_rs1_sel, fwd_rs2_sel, mem_timeout};
    endfunction

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v; rs1_addr_id = r1; rs1_used = u1; rs2_addr_id = r2; rs2_used = u2;
        rd_addr_id = rd; rd_wr_en_id = wr; data_rd_en_id = ld;
    endtask

    task automatic set_mem(input logic req, input logic rdy);
        data_req = req; data_ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clk_en = 1; branch_taken = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_mem(0, 0);
        rst_n = 0;
        cyc();
        @(negedge clk);
        rst_n = 1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 0; clk_en = 1; branch_taken = 1;
        set_id(1, 5, 1, 5, 1, 5, 1, 1);
        set_mem(1, 0);
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== 10'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected 000", dut_vec());
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== 10'd0) begin
            n_bad++; $display("FAIL idle_after_reset: got %h expected 000", dut_vec());
        end
    endtask

    task automatic test_forward_alu();
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'd0) begin
            n_bad++; $display("FAIL alu_first_fwd: got %0d/%0d expected 0/0", fwd_rs1_sel, fwd_rs2_sel);
        end
        cyc();
        set_id(1, 5, 1, 5, 1, 6, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({fwd_rs1_sel, fwd_rs2_sel, stall_if, bubble_ex} !== 6'b01_01_0_0) begin
            n_bad++; $display("FAIL alu_b2b_fwd: got %0d/%0d stall=%b bubble=%b expected 1/1 0 0",
                              fwd_rs1_sel, fwd_rs2_sel, stall_if, bubble_ex);
        end
        cyc();
        set_id(1, 9, 1, 10, 1, 11, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'd0) begin
            n_bad++; $display("FAIL alu_nomatch_fwd: got %0d/%0d expected 0/0", fwd_rs1_sel, fwd_rs2_sel);
        end
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 2, 1, 0, 0, 7, 1, 1);
        cyc();
        set_id(1, 7, 1, 1, 1, 8, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({stall_if, stall_id, bubble_ex} !== 3'b111) begin
            n_bad++; $display("FAIL lu_stall: got %b%b%b expected 111", stall_if, stall_id, bubble_ex);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if ({stall_if, stall_id, bubble_ex, fwd_rs1_sel, fwd_rs2_sel} !== 7'b000_10_00) begin
            n_bad++; $display("FAIL lu_release: got stalls %b%b%b fwd %0d/%0d expected 000 2/0",
                              stall_if, stall_id, bubble_ex, fwd_rs1_sel, fwd_rs2_sel);
        end
        cyc();
    endtask

    task automatic test_load_x0();
        do_reset();
        set_id(1, 2, 1, 0, 0, 0, 1, 1);
        cyc();
        set_id(1, 0, 1, 0, 1, 3, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({stall_if, bubble_ex, fwd_rs1_sel, fwd_rs2_sel} !== 6'd0) begin
            n_bad++; $display("FAIL load_x0: got stall=%b bubble=%b fwd %0d/%0d expected 0 0 0/0",
                              stall_if, bubble_ex, fwd_rs1_sel, fwd_rs2_sel);
        end
        cyc();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        cyc();
        set_id(1, 5, 1, 0, 0, 9, 0, 0);
        set_mem(1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({freeze, stall_if, stall_id, bubble_ex, fwd_rs1_sel} !== 6'b1110_01) begin
                n_bad++; $display("FAIL wait_freeze%0d: got f=%b s=%b%b b=%b fwd=%0d expected 1 11 0 1",
                                  k, freeze, stall_if, stall_id, bubble_ex, fwd_rs1_sel);
            end
            cyc();
        end
        set_mem(1, 1);
        @(negedge clk);
        n_cmp++;
        if ({freeze, stall_if, fwd_rs1_sel, mem_timeout} !== 5'b00_01_0) begin
            n_bad++; $display("FAIL wait_ready: got f=%b s=%b fwd=%0d to=%b expected 0 0 1 0",
                              freeze, stall_if, fwd_rs1_sel, mem_timeout);
        end
        cyc();
        set_mem(0, 0);
        @(negedge clk);
        n_cmp++;
        if (fwd_rs1_sel !== 2'd2) begin
            n_bad++; $display("FAIL wait_advanced: got fwd=%0d expected 2", fwd_rs1_sel);
        end
        cyc();
    endtask

    task automatic test_timeout();
        do_reset();
        set_mem(1, 0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_timeout !== (k >= 5)) begin
                n_bad++; $display("FAIL timeout_cyc%0d: got %b expected %b", k, mem_timeout, k >= 5);
            end
            cyc();
        end
        set_mem(0, 1);
        repeat (3) begin
            cyc();
            n_cmp++;
            if (mem_timeout !== 1'b1) begin
                n_bad++; $display("FAIL timeout_sticky: got %b expected 1", mem_timeout);
            end
        end
        set_mem(0, 0);
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++;
        if (mem_timeout !== 1'b0) begin
            n_bad++; $display("FAIL timeout_clear: got %b expected 0", mem_timeout);
        end
        do_reset();
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_id(1, 2, 1, 0, 0, 7, 1, 1);
        cyc();
        set_id(1, 7, 1, 0, 0, 8, 1, 0);
        branch_taken = 1;
        @(negedge clk);
        n_cmp++;
        if ({flush_if, stall_if, bubble_ex} !== 3'b011) begin
            n_bad++; $display("FAIL branch_vs_lu: got flush=%b stall=%b bubble=%b expected 0 1 1",
                              flush_if, stall_if, bubble_ex);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if ({flush_if, stall_if} !== 2'b10) begin
            n_bad++; $display("FAIL branch_after_lu: got flush=%b stall=%b expected 1 0", flush_if, stall_if);
        end
        cyc();
        branch_taken = 0;
        @(negedge clk);
        n_cmp++;
        if (flush_if !== 1'b0) begin
            n_bad++; $display("FAIL branch_one_cycle: got flush=%b expected 0", flush_if);
        end
        cyc();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        cyc();
        set_id(1, 5, 1, 0, 0, 9, 0, 0);
        set_mem(1, 0);
        cyc();
        cyc();
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (dut_vec() !== 10'd0) begin
            n_bad++; $display("FAIL rst_in_wait: got %h expected 000", dut_vec());
        end
        cyc();
        set_mem(0, 0);
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({fwd_rs1_sel, freeze} !== 3'd0) begin
            n_bad++; $display("FAIL rst_tracking: got fwd=%0d freeze=%b expected 0 0", fwd_rs1_sel, freeze);
        end
        cyc();
        set_mem(1, 0);
        repeat (3) cyc();
        n_cmp++;
        if (mem_timeout !== 1'b0) begin
            n_bad++; $display("FAIL rst_counter: got timeout=%b expected 0", mem_timeout);
        end
        set_mem(0, 1);
        cyc();
        set_mem(0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            clk_en       = ($urandom_range(0, 99) < 85);
            branch_taken = ($urandom_range(0, 99) < 20);
            set_id($urandom_range(0, 99) < 80, 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), ($urandom_range(0, 99) < 40));
            set_mem($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60);
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (dut_vec() !== e_vec) begin
                n_bad++; $display("FAIL random_%0d: got %b expected %b", n, dut_vec(), e_vec);
            end
            cyc();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward_alu();
        test_load_use();
        test_load_x0();
        test_mem_wait();
        test_timeout();
        test_branch_lu();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
